// File: rtl/fib_seq_if.sv
// Command/result handshake bundle for fib_seq_engine: valid/ready command
// channel in, registered valid/ready result channel out, plus status.
interface fib_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             ovf;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    output cmd_valid, cmd_op, load_a, load_b, out_ready,
    input  cmd_ready, out_valid, out_data, ovf, step_cnt
  );

  modport slave (
    input  cmd_valid, cmd_op, load_a, load_b, out_ready,
    output cmd_ready, out_valid, out_data, ovf, step_cnt
  );
endinterface

// File: rtl/fib_seq_engine.sv
// Fibonacci pair engine: PEEK/STEP/LOAD/RESTART commands update (a,b) and
// return the new a through a one-entry registered output stage.
module fib_seq_engine #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned SEED0    = 0,
  parameter int unsigned SEED1    = 1,
  parameter bit          SATURATE = 1'b0
) (
  input logic     clk,
  input logic     rst,
  fib_seq_if.slave bus
);

  localparam logic [1:0] OpPeek    = 2'b00;
  localparam logic [1:0] OpStep    = 2'b01;
  localparam logic [1:0] OpLoad    = 2'b10;
  localparam logic [1:0] OpRestart = 2'b11;

  localparam logic [WIDTH-1:0] Seed0  = WIDTH'(SEED0);
  localparam logic [WIDTH-1:0] Seed1  = WIDTH'(SEED1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             accept;
  logic [WIDTH:0]   sum;

  // A pending beat only blocks new commands while the consumer stalls.
  assign bus.cmd_ready = !out_valid_q || bus.out_ready;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign sum           = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (accept) begin
      case (bus.cmd_op)
        OpPeek: ;
        OpStep: begin
          a_d = b_q;
          if (sum[WIDTH]) begin
            ovf_d = 1'b1;
            b_d   = SATURATE ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
          end else begin
            b_d = sum[WIDTH-1:0];
          end
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        end
        OpLoad: begin
          a_d   = bus.load_a;
          b_d   = bus.load_b;
          ovf_d = 1'b0;
          cnt_d = '0;
        end
        OpRestart: begin
          a_d   = Seed0;
          b_d   = Seed1;
          ovf_d = 1'b0;
          cnt_d = '0;
        end
        default: ;
      endcase
      out_data_d  = a_d;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= Seed0;
      b_q         <= Seed1;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.ovf       = ovf_q;
  assign bus.step_cnt  = cnt_q;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Directed bench: three engine variants (wrap, saturate, 2-bit counter) share
// one command stream; a vector table plus handshake/reset corner sequences.
module tb_fib_seq_engine;

  localparam logic [1:0] OpPeek    = 2'b00;
  localparam logic [1:0] OpStep    = 2'b01;
  localparam logic [1:0] OpLoad    = 2'b10;
  localparam logic [1:0] OpRestart = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = OpPeek;
  logic [7:0] load_a = '0;
  logic [7:0] load_b = '0;
  logic       out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fib_seq_if #(.WIDTH(8), .CNT_W(16)) if_w ();
  fib_seq_if #(.WIDTH(8), .CNT_W(16)) if_s ();
  fib_seq_if #(.WIDTH(8), .CNT_W(2))  if_c ();

  assign if_w.cmd_valid = cmd_valid;
  assign if_w.cmd_op    = cmd_op;
  assign if_w.load_a    = load_a;
  assign if_w.load_b    = load_b;
  assign if_w.out_ready = out_ready;
  assign if_s.cmd_valid = cmd_valid;
  assign if_s.cmd_op    = cmd_op;
  assign if_s.load_a    = load_a;
  assign if_s.load_b    = load_b;
  assign if_s.out_ready = out_ready;
  assign if_c.cmd_valid = cmd_valid;
  assign if_c.cmd_op    = cmd_op;
  assign if_c.load_a    = load_a;
  assign if_c.load_b    = load_b;
  assign if_c.out_ready = out_ready;

  fib_seq_engine #(.WIDTH(8), .CNT_W(16), .SEED0(0), .SEED1(1), .SATURATE(1'b0)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (if_w.slave)
  );
  fib_seq_engine #(.WIDTH(8), .CNT_W(16), .SEED0(0), .SEED1(1), .SATURATE(1'b1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (if_s.slave)
  );
  fib_seq_engine #(.WIDTH(8), .CNT_W(2), .SEED0(0), .SEED1(1), .SATURATE(1'b0)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (if_c.slave)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] la;
    logic [7:0] lb;
    int         d_w;  // wrap variant out_data
    int         o_w;
    int         c_w;
    int         d_s;  // saturating variant out_data
    int         o_s;
    int         c_c;  // 2-bit counter variant step_cnt
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] op, logic [7:0] la, logic [7:0] lb, int d_w, int o_w,
                              int c_w, int d_s, int o_s, int c_c);
    vec_t v;
    v.op = op; v.la = la; v.lb = lb;
    v.d_w = d_w; v.o_w = o_w; v.c_w = c_w;
    v.d_s = d_s; v.o_s = o_s; v.c_c = c_c;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int fib[13] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    for (int k = 1; k <= 13; k++) begin
      vecs.push_back(mk(OpStep, 8'd0, 8'd0, fib[k-1], (k == 13) ? 1 : 0, k,
                        fib[k-1], (k == 13) ? 1 : 0, (k < 3) ? k : 3));
    end
    vecs.push_back(mk(OpStep,    8'd0,   8'd0,  121, 1, 14, 255, 1, 3));
    vecs.push_back(mk(OpStep,    8'd0,   8'd0,   98, 1, 15, 255, 1, 3));
    vecs.push_back(mk(OpPeek,    8'd0,   8'd0,   98, 1, 15, 255, 1, 3));
    vecs.push_back(mk(OpLoad,    8'd250, 8'd10, 250, 0,  0, 250, 0, 0));
    vecs.push_back(mk(OpStep,    8'd0,   8'd0,   10, 1,  1,  10, 1, 1));
    vecs.push_back(mk(OpStep,    8'd0,   8'd0,    4, 1,  2, 255, 1, 2));
    vecs.push_back(mk(OpRestart, 8'd0,   8'd0,    0, 0,  0,   0, 0, 0));
    vecs.push_back(mk(OpStep,    8'd0,   8'd0,    1, 0,  1,   1, 0, 1));

    // Reset state
    do_reset();
    check("rst out_valid", int'(if_w.out_valid), 0);
    check("rst out_data", int'(if_w.out_data), 0);
    check("rst ovf", int'(if_w.ovf), 0);
    check("rst step_cnt", int'(if_w.step_cnt), 0);
    check("rst cmd_ready", int'(if_w.cmd_ready), 1);

    // Full-throughput vector run
    out_ready = 1'b1;
    cmd_valid = 1'b1;
    foreach (vecs[i]) begin
      cmd_op = vecs[i].op;
      load_a = vecs[i].la;
      load_b = vecs[i].lb;
      tick();
      check($sformatf("v%0d valid", i), int'(if_w.out_valid), 1);
      check($sformatf("v%0d wrap data", i), int'(if_w.out_data), vecs[i].d_w);
      check($sformatf("v%0d wrap ovf", i), int'(if_w.ovf), vecs[i].o_w);
      check($sformatf("v%0d wrap cnt", i), int'(if_w.step_cnt), vecs[i].c_w);
      check($sformatf("v%0d sat data", i), int'(if_s.out_data), vecs[i].d_s);
      check($sformatf("v%0d sat ovf", i), int'(if_s.ovf), vecs[i].o_s);
      check($sformatf("v%0d cnt2", i), int'(if_c.step_cnt), vecs[i].c_c);
    end
    cmd_valid = 1'b0;
    tick();
    check("drain valid", int'(if_w.out_valid), 0);
    check("drain data hold", int'(if_w.out_data), 1);

    // Backpressure: second STEP held while the first beat stalls
    do_reset();
    out_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OpStep;
    tick();
    check("bp first data", int'(if_w.out_data), 1);
    check("bp first valid", int'(if_w.out_valid), 1);
    check("bp stall ready", int'(if_w.cmd_ready), 0);
    tick();
    tick();
    check("bp frozen data", int'(if_w.out_data), 1);
    check("bp frozen cnt", int'(if_w.step_cnt), 1);
    out_ready = 1'b1;
    #1;
    check("bp comb ready", int'(if_w.cmd_ready), 1);
    tick();
    check("bp second valid", int'(if_w.out_valid), 1);
    check("bp second data", int'(if_w.out_data), 1);
    check("bp second cnt", int'(if_w.step_cnt), 2);
    tick();
    check("bp third data", int'(if_w.out_data), 2);
    cmd_valid = 1'b0;
    tick();
    check("bp drained", int'(if_w.out_valid), 0);

    // Reset while a beat is stalled and a STEP is pending
    out_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OpLoad;
    load_a    = 8'd250;
    load_b    = 8'd10;
    tick();
    cmd_op = OpStep;
    tick();
    check("pre-rst ovf", int'(if_w.ovf), 1);
    out_ready = 1'b0;
    tick();
    check("pre-rst stalled", int'(if_w.cmd_ready), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst valid", int'(if_w.out_valid), 0);
    check("mid rst data", int'(if_w.out_data), 0);
    check("mid rst ovf", int'(if_w.ovf), 0);
    check("mid rst cnt", int'(if_w.step_cnt), 0);
    check("mid rst ready", int'(if_w.cmd_ready), 1);
    cmd_op = OpPeek;
    out_ready = 1'b1;
    tick();
    check("post rst peek", int'(if_w.out_data), 0);
    check("post rst peek valid", int'(if_w.out_valid), 1);
    cmd_op = OpStep;
    tick();
    check("post rst step", int'(if_w.out_data), 1);
    tick();
    check("post rst step2", int'(if_w.out_data), 1);
    cmd_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
